// File: rtl/hazard_ctrl.sv
// Hazard control for a 5-stage pipeline with ID-stage branch compare.
// Tracks EX/MEM/WB destinations; drives EX/ID forward selects, stall and bubble.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   rs_id, rt_id, use_rs_id,
//   use_rt_id, branch_id            operand usage of the ID instruction
//   a3_id, regwrite_id, memtoreg_id destination info of the ID instruction
//   forward_a_ex, forward_b_ex      EX operand selects (00 rf, 01 wb, 10 mem)
//   forward_a_id, forward_b_id      ID compare selects (0 rf, 1 mem)
//   stall, bubble_ex                hold PC/IF-ID, squash into ID/EX
//   a3_mem, a3_wb                   tracked destinations
module hazard_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       use_rs_id,
  input  logic       use_rt_id,
  input  logic       branch_id,
  input  logic [4:0] a3_id,
  input  logic       regwrite_id,
  input  logic       memtoreg_id,
  output logic [1:0] forward_a_ex,
  output logic [1:0] forward_b_ex,
  output logic       forward_a_id,
  output logic       forward_b_id,
  output logic       stall,
  output logic       bubble_ex,
  output logic [4:0] a3_mem,
  output logic [4:0] a3_wb
);

  logic [4:0] rs_ex_q, rs_ex_d;
  logic [4:0] rt_ex_q, rt_ex_d;
  logic [4:0] a3_ex_q, a3_ex_d;
  logic       rw_ex_q, rw_ex_d;
  logic       mtr_ex_q, mtr_ex_d;

  logic [4:0] a3_mem_q, a3_mem_d;
  logic       rw_mem_q, rw_mem_d;
  logic       mtr_mem_q, mtr_mem_d;

  logic [4:0] a3_wb_q, a3_wb_d;
  logic       rw_wb_q, rw_wb_d;

  logic ex_wr, mem_wr, wb_wr;
  logic match_ex, match_mem;
  logic stall_w;

  // Register 0 is hard-wired, so it never counts as a produced value.
  assign ex_wr  = rw_ex_q  && (a3_ex_q  != 5'd0);
  assign mem_wr = rw_mem_q && (a3_mem_q != 5'd0);
  assign wb_wr  = rw_wb_q  && (a3_wb_q  != 5'd0);

  assign match_ex =
    ex_wr &&
    ((use_rs_id && (a3_ex_q == rs_id)) ||
     (use_rt_id && (a3_ex_q == rt_id)));

  assign match_mem =
    mem_wr &&
    ((use_rs_id && (a3_mem_q == rs_id)) ||
     (use_rt_id && (a3_mem_q == rt_id)));

  // Loads produce only at the end of MEM; branches consume in ID,
  // so a branch must wait for any EX producer and for a MEM load.
  assign stall_w =
    (mtr_ex_q && match_ex) ||
    (branch_id && match_ex) ||
    (branch_id && mtr_mem_q && match_mem);

  assign stall     = stall_w;
  assign bubble_ex = stall_w;

  always_comb begin
    forward_a_ex = 2'b00;
    if (mem_wr && (a3_mem_q == rs_ex_q))
      forward_a_ex = 2'b10;
    else if (wb_wr && (a3_wb_q == rs_ex_q))
      forward_a_ex = 2'b01;
  end

  always_comb begin
    forward_b_ex = 2'b00;
    if (mem_wr && (a3_mem_q == rt_ex_q))
      forward_b_ex = 2'b10;
    else if (wb_wr && (a3_wb_q == rt_ex_q))
      forward_b_ex = 2'b01;
  end

  // WB values reach ID through the write-first register file.
  assign forward_a_id =
    branch_id && use_rs_id && !stall_w &&
    mem_wr && !mtr_mem_q && (a3_mem_q == rs_id);

  assign forward_b_id =
    branch_id && use_rt_id && !stall_w &&
    mem_wr && !mtr_mem_q && (a3_mem_q == rt_id);

  assign a3_mem = a3_mem_q;
  assign a3_wb  = a3_wb_q;

  always_comb begin
    rs_ex_d  = rs_id;
    rt_ex_d  = rt_id;
    a3_ex_d  = a3_id;
    rw_ex_d  = regwrite_id;
    mtr_ex_d = memtoreg_id;
    if (stall_w) begin
      rs_ex_d  = 5'd0;
      rt_ex_d  = 5'd0;
      a3_ex_d  = 5'd0;
      rw_ex_d  = 1'b0;
      mtr_ex_d = 1'b0;
    end
    a3_mem_d  = a3_ex_q;
    rw_mem_d  = rw_ex_q;
    mtr_mem_d = mtr_ex_q;
    a3_wb_d   = a3_mem_q;
    rw_wb_d   = rw_mem_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_ex_q   <= 5'd0;
      rt_ex_q   <= 5'd0;
      a3_ex_q   <= 5'd0;
      rw_ex_q   <= 1'b0;
      mtr_ex_q  <= 1'b0;
      a3_mem_q  <= 5'd0;
      rw_mem_q  <= 1'b0;
      mtr_mem_q <= 1'b0;
      a3_wb_q   <= 5'd0;
      rw_wb_q   <= 1'b0;
    end else begin
      rs_ex_q   <= rs_ex_d;
      rt_ex_q   <= rt_ex_d;
      a3_ex_q   <= a3_ex_d;
      rw_ex_q   <= rw_ex_d;
      mtr_ex_q  <= mtr_ex_d;
      a3_mem_q  <= a3_mem_d;
      rw_mem_q  <= rw_mem_d;
      mtr_mem_q <= mtr_mem_d;
      a3_wb_q   <= a3_wb_d;
      rw_wb_q   <= rw_wb_d;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: stage-record model checked every cycle,
// plus directed pipeline scenarios with literal expectations.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] rs_id, rt_id, a3_id;
  logic       use_rs_id, use_rt_id, branch_id;
  logic       regwrite_id, memtoreg_id;
  logic [1:0] forward_a_ex, forward_b_ex;
  logic       forward_a_id, forward_b_id;
  logic       stall, bubble_ex;
  logic [4:0] a3_mem, a3_wb;

  int n_chk  = 0;
  int n_fail = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  hazard_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .rs_id        (rs_id),
    .rt_id        (rt_id),
    .use_rs_id    (use_rs_id),
    .use_rt_id    (use_rt_id),
    .branch_id    (branch_id),
    .a3_id        (a3_id),
    .regwrite_id  (regwrite_id),
    .memtoreg_id  (memtoreg_id),
    .forward_a_ex (forward_a_ex),
    .forward_b_ex (forward_b_ex),
    .forward_a_id (forward_a_id),
    .forward_b_id (forward_b_id),
    .stall        (stall),
    .bubble_ex    (bubble_ex),
    .a3_mem       (a3_mem),
    .a3_wb        (a3_wb)
  );

  // Model: one instruction record per stage, 0=EX 1=MEM 2=WB.
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] a3;
    logic       rw;
    logic       ld;
  } ins_t;

  ins_t st [3] = '{default: '0};

  // Youngest stage (from lo upward) producing src, or 3 if none.
  function automatic int producer(input logic [4:0] src, input int lo);
    for (int k = lo; k < 3; k++)
      if (st[k].rw && st[k].a3 != 5'd0 && st[k].a3 == src)
        return k;
    return 3;
  endfunction

  // A value is usable once its producer has reached ready stage:
  // ALU results from MEM on (1), load data from WB on (2).
  // A branch consumes now; an ALU op consumes one cycle later.
  function automatic bit src_stalls(input logic [4:0] src);
    int p, ready;
    p = producer(src, 0);
    if (p == 3) return 1'b0;
    ready = st[p].ld ? 2 : 1;
    if (branch_id) return p < ready;
    return (p + 1) < ready;
  endfunction

  function automatic bit m_stall();
    return (use_rs_id && src_stalls(rs_id)) ||
           (use_rt_id && src_stalls(rt_id));
  endfunction

  function automatic logic [1:0] m_fwd_ex(input logic [4:0] src);
    case (producer(src, 1))
      1:       return 2'b10;
      2:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic m_fwd_id(input logic [4:0] src, input logic u);
    return branch_id && u && !m_stall() && producer(src, 0) == 1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      st[0] <= '0;
      st[1] <= '0;
      st[2] <= '0;
    end else begin
      st[2] <= st[1];
      st[1] <= st[0];
      if (m_stall())
        st[0] <= '0;
      else
        st[0] <= '{rs: rs_id, rt: rt_id, a3: a3_id,
                   rw: regwrite_id, ld: memtoreg_id};
    end
  end

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      chk("m_fwd_a_ex", 8'(forward_a_ex), 8'(m_fwd_ex(st[0].rs)));
      chk("m_fwd_b_ex", 8'(forward_b_ex), 8'(m_fwd_ex(st[0].rt)));
      chk("m_fwd_a_id", 8'(forward_a_id), 8'(m_fwd_id(rs_id, use_rs_id)));
      chk("m_fwd_b_id", 8'(forward_b_id), 8'(m_fwd_id(rt_id, use_rt_id)));
      chk("m_stall", 8'(stall), 8'(m_stall()));
      chk("m_bubble", 8'(bubble_ex), 8'(m_stall()));
      chk("m_a3_mem", 8'(a3_mem), 8'(st[1].a3));
      chk("m_a3_wb", 8'(a3_wb), 8'(st[2].a3));
    end
  end

  // Present one ID instruction after the edge; return late in the cycle.
  task automatic drive(input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic br,
                       input logic [4:0] a3, input logic rw,
                       input logic ld);
    @(posedge clk);
    #1;
    reset       = 1'b0;
    rs_id       = rs;
    rt_id       = rt;
    use_rs_id   = urs;
    use_rt_id   = urt;
    branch_id   = br;
    a3_id       = a3;
    regwrite_id = rw;
    memtoreg_id = ld;
    #7;
  endtask

  task automatic nop();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic flush();
    repeat (3) nop();
  endtask

  initial begin
    reset = 1'b1;
    rs_id = 0; rt_id = 0; a3_id = 0;
    use_rs_id = 0; use_rt_id = 0; branch_id = 0;
    regwrite_id = 0; memtoreg_id = 0;
    @(posedge clk);
    #1;
    check_en = 1'b1;
    @(posedge clk);
    #8;
    chk("rst_stall", 8'(stall), 8'd0);
    chk("rst_fwd_a_ex", 8'(forward_a_ex), 8'd0);
    chk("rst_a3_mem", 8'(a3_mem), 8'd0);
    chk("rst_a3_wb", 8'(a3_wb), 8'd0);

    // ALU -> ALU: add $3, sub $6 <- $3, or $8 <- $7,$3
    flush();
    drive(1, 2, 1, 1, 0, 3, 1, 0);
    drive(3, 4, 1, 1, 0, 6, 1, 0);
    chk("alu_stall", 8'(stall), 8'd0);
    drive(7, 3, 1, 1, 0, 8, 1, 0);
    chk("alu_fwd_mem", 8'(forward_a_ex), 8'd2);
    nop();
    chk("alu_fwd_wb", 8'(forward_b_ex), 8'd1);

    // load-use: lw $5 ; add $9 <- $2,$5
    flush();
    drive(1, 0, 1, 0, 0, 5, 1, 1);
    drive(2, 5, 1, 1, 0, 9, 1, 0);
    chk("lu_stall", 8'(stall), 8'd1);
    chk("lu_bubble", 8'(bubble_ex), 8'd1);
    drive(2, 5, 1, 1, 0, 9, 1, 0);
    chk("lu_stall_end", 8'(stall), 8'd0);
    nop();
    chk("lu_fwd_wb", 8'(forward_b_ex), 8'd1);

    // load -> branch: lw $7 ; beq $7,$0
    flush();
    drive(1, 0, 1, 0, 0, 7, 1, 1);
    drive(7, 0, 1, 1, 1, 0, 0, 0);
    chk("lb_stall1", 8'(stall), 8'd1);
    drive(7, 0, 1, 1, 1, 0, 0, 0);
    chk("lb_stall2", 8'(stall), 8'd1);
    drive(7, 0, 1, 1, 1, 0, 0, 0);
    chk("lb_stall3", 8'(stall), 8'd0);
    chk("lb_fwd_id", 8'(forward_a_id), 8'd0);

    // ALU -> branch: add $11 ; beq $11,$11
    flush();
    drive(1, 2, 1, 1, 0, 11, 1, 0);
    drive(11, 11, 1, 1, 1, 0, 0, 0);
    chk("ab_stall", 8'(stall), 8'd1);
    drive(11, 11, 1, 1, 1, 0, 0, 0);
    chk("ab_stall_end", 8'(stall), 8'd0);
    chk("ab_fwd_a_id", 8'(forward_a_id), 8'd1);
    chk("ab_fwd_b_id", 8'(forward_b_id), 8'd1);

    // register zero
    flush();
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 1, 1, 1, 0, 0, 0);
    chk("r0_stall", 8'(stall), 8'd0);
    chk("r0_fwd_id", 8'(forward_a_id), 8'd0);
    nop();
    chk("r0_fwd_ex", 8'(forward_a_ex), 8'd0);

    // double match: MEM and WB both write $4
    flush();
    drive(1, 2, 1, 1, 0, 4, 1, 0);
    drive(1, 2, 1, 1, 0, 4, 1, 0);
    drive(4, 4, 1, 1, 0, 10, 1, 0);
    nop();
    chk("dm_fwd_a", 8'(forward_a_ex), 8'd2);
    chk("dm_fwd_b", 8'(forward_b_ex), 8'd2);

    // reset during first stall cycle of load -> branch
    flush();
    drive(1, 0, 1, 0, 0, 7, 1, 1);
    drive(7, 0, 1, 1, 1, 0, 0, 0);
    chk("rs_stall", 8'(stall), 8'd1);
    reset = 1'b1;
    drive(7, 0, 1, 1, 1, 0, 0, 0);
    chk("rs_stall_gone", 8'(stall), 8'd0);
    chk("rs_fwd_id", 8'(forward_a_id), 8'd0);
    chk("rs_a3_mem", 8'(a3_mem), 8'd0);
    flush();

    @(posedge clk);
    #1;
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset; ports: clk  in  1  rising-edge clock; reset  in  1  synchronous active-high reset.
REQ-002 Inputs: rs_id, rt_id  in  5 each  source register numbers of the instruction in ID.
REQ-003 Inputs: use_rs_id, use_rt_id  in  1 each  the ID instruction reads rs / rt.
REQ-004 Input: branch_id  in  1  the ID instruction compares operands in ID.
REQ-005 Input: a3_id  in  5  destination register of the ID instruction.
REQ-006 Inputs: regwrite_id, memtoreg_id  in  1 each  the ID instruction writes the register file / is a load.
REQ-007 Outputs: forward_a_ex, forward_b_ex  out  2 each  EX operand selects; 00 = register-file value, 01 = wd_wb, 10 = aluout_mem; 11 is never driven.
REQ-008 Outputs: forward_a_id, forward_b_id  out  1 each  ID compare operand selects; 0 = register-file value, 1 = aluout_mem.
REQ-009 Outputs: stall  out  1  hold PC and IF/ID; bubble_ex  out  1  load a NOP into ID/EX.
REQ-010 Outputs: a3_mem, a3_wb  out  5 each  tracked destinations, for observability.

Function
REQ-011 The block SHALL track three stages in registers: EX {rs, rt, a3, regwrite, memtoreg}, MEM {a3, regwrite, memtoreg} and WB {a3, regwrite}.
REQ-012 On each clock edge with stall=0, the EX tracking registers SHALL load the ID inputs.
REQ-013 On each clock edge with stall=1, the EX tracking registers SHALL load a bubble: all fields 0.
REQ-014 EX->MEM and MEM->WB tracking SHALL advance on every edge, regardless of stall.
REQ-015 A stage SHALL be a "writer" only when regwrite=1 and a3 is not 0; register 0 SHALL never match.
REQ-016 forward_a_ex SHALL be 10 if the MEM stage is a writer and a3_mem equals rs_ex; otherwise 01 if the WB stage is a writer and a3_wb equals rs_ex; otherwise 00. MEM SHALL take priority over WB.
REQ-017 forward_b_ex SHALL follow the same rule as REQ-016, using rt_ex.
REQ-018 forward_*_ex SHALL be combinational from the tracking registers only, with zero-cycle latency.
REQ-019 "Match(X)" SHALL mean stage X is a writer and its a3 equals rs_id with use_rs_id=1, or equals rt_id with use_rt_id=1.
REQ-020 Load-use stall: stall SHALL be 1 when memtoreg_ex=1 and Match(EX).
REQ-021 Branch stall: stall SHALL be 1 when branch_id=1 and Match(EX), for both ALU and load instructions in EX.
REQ-022 Branch stall: stall SHALL be 1 when branch_id=1, memtoreg_mem=1 and Match(MEM).
REQ-023 Consequence of REQ-020 to REQ-022: a load followed immediately by a dependent ALU instruction stalls exactly 1 cycle; a load followed immediately by a dependent branch stalls exactly 2 cycles; an ALU instruction followed immediately by a dependent branch stalls exactly 1 cycle.
REQ-024 bubble_ex SHALL equal stall in every cycle.
REQ-025 forward_a_id SHALL be 1 when branch_id=1, use_rs_id=1, stall=0, the MEM stage is a writer, memtoreg_mem=0 and a3_mem equals rs_id; otherwise 0.
REQ-026 forward_b_id SHALL follow the same rule as REQ-025, using rt_id and use_rt_id.
REQ-027 WB->ID hazards SHALL NOT be forwarded; the register file is write-first within the cycle.
REQ-028 aluout_mem SHALL never be selected while MEM holds a load; the stall rules guarantee this, and the block does not recheck it.
REQ-029 When both operands match different stages, each select SHALL be resolved independently.
REQ-030 When rs_id equals rt_id, both selects SHALL take the same value.

Reset
REQ-031 On reset=1 at a clock edge, all tracking registers SHALL clear to 0.
REQ-032 During the cycle after a reset edge: forward_*_ex=00, forward_*_id=0, stall=0, bubble_ex=0, a3_mem=0, a3_wb=0.
REQ-033 Reset SHALL take priority over stall.
REQ-034 A reset asserted mid-stall SHALL terminate the stall in the next cycle, with no pending bubbles carried over.

Verification
REQ-035 ALU then ALU dependency: add $3 written in EX; next cycle sub reads $3 -> forward_a_ex=10 for 1 cycle, stall=0; one instruction later the reader sees forward_a_ex=01.
REQ-036 Load-use: lw $5 in EX, ID reads rt=$5 with use_rt_id=1 -> stall=1 and bubble_ex=1 for exactly 1 cycle, then forward_b_ex=01.
REQ-037 Load then branch: lw $7, then beq on $7 -> stall=1 for 2 consecutive cycles, then forward_*_id=0 because the value arrives through the write-first register file.
REQ-038 Register zero: a writer with a3=0 and readers with rs=0 -> all selects 00/0, stall=0.
REQ-039 Double match: MEM writer a3=$4 and WB writer a3=$4, EX rs=$4 -> forward_a_ex=10 (MEM priority).
REQ-040 Reset mid-stall: assert reset during the first stall cycle of REQ-037 -> the next cycle has stall=0 and all selects 0.
